bf16_div: RTL and testbench



---
 rtl/ibex_pkg.sv | 30 +++
 rtl/FP_Class.sv | 29 ++
 rtl/bf16_div.sv | 216 +++++++++++++++++++++
 tb/tb_bf16_div.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/ibex_pkg.sv
// Shared bfloat16 constants, operand layout and divider state encoding for the FPU.
package ibex_pkg;

    localparam int unsigned BF16_W     = 16;
    localparam int unsigned BF16_EXP_W = 8;
    localparam int unsigned BF16_MAN_W = 7;
    localparam int unsigned BF16_SIG_W = BF16_MAN_W + 1;
    localparam int unsigned DIV_Q_W    = 10;
    localparam int unsigned DIV_CNT_W  = 4;
    localparam int unsigned DIV_EXP_W  = 10;

    localparam logic [BF16_W-1:0]    BF16_QNAN        = 16'h7FC0;
    localparam logic [BF16_W-2:0]    BF16_POS_INF_MAG = 15'h7F80;
    localparam int unsigned          BF16_BIAS        = 127;
    localparam logic [DIV_CNT_W-1:0] DIV_LAST         = 4'd9;

    typedef struct packed {
        logic                  sign;
        logic [BF16_EXP_W-1:0] exp;
        logic [BF16_MAN_W-1:0] man;
    } bf16_t;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        NORM,
        DONE
    } div_state_e;

endpackage

// File: rtl/FP_Class.sv
// bfloat16 operand classifier shared with the multiplier; subnormals are reported separately.
module FP_Class
    import ibex_pkg::*;
(
    input  logic [BF16_W-1:0] x_i,
    output logic              inf_o,
    output logic              neg_inf_o,
    output logic              nan_o,
    output logic              sub_norm_o,
    output logic              zero_o
);

    bf16_t x;
    logic  exp_max;
    logic  exp_min;
    logic  man_zero;

    assign x        = bf16_t'(x_i);
    assign exp_max  = (x.exp == '1);
    assign exp_min  = (x.exp == '0);
    assign man_zero = (x.man == '0);

    assign inf_o      = exp_max & man_zero & ~x.sign;
    assign neg_inf_o  = exp_max & man_zero &  x.sign;
    assign nan_o      = exp_max & ~man_zero;
    assign sub_norm_o = exp_min & ~man_zero;
    assign zero_o     = exp_min &  man_zero;

endmodule

// File: rtl/bf16_div.sv
// Sequential bfloat16 divider: restoring division, one quotient bit per clock, RNE rounding.
module bf16_div
    import ibex_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [BF16_W-1:0] a_i,
    input  logic [BF16_W-1:0] b_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [BF16_W-1:0] c_o
);

    bf16_t a;
    bf16_t b;
    assign a = bf16_t'(a_i);
    assign b = bf16_t'(b_i);

    logic a_inf, a_ninf, a_nan, a_sub, a_zero;
    logic b_inf, b_ninf, b_nan, b_sub, b_zero;

    FP_Class u_class_a (
        .x_i        (a_i),
        .inf_o      (a_inf),
        .neg_inf_o  (a_ninf),
        .nan_o      (a_nan),
        .sub_norm_o (a_sub),
        .zero_o     (a_zero)
    );

    FP_Class u_class_b (
        .x_i        (b_i),
        .inf_o      (b_inf),
        .neg_inf_o  (b_ninf),
        .nan_o      (b_nan),
        .sub_norm_o (b_sub),
        .zero_o     (b_zero)
    );

    div_state_e             state_q, state_d;
    logic [DIV_CNT_W-1:0]   cnt_q, cnt_d;
    logic [DIV_Q_W-1:0]     q_q, q_d;
    logic [DIV_Q_W-1:0]     rem_q, rem_d;
    logic [BF16_SIG_W-1:0]  sb_q, sb_d;
    logic [BF16_EXP_W-1:0]  ea_q, ea_d;
    logic [BF16_EXP_W-1:0]  eb_q, eb_d;
    logic                   sign_q, sign_d;
    logic [BF16_W-1:0]      c_q, c_d;
    logic                   valid_q, valid_d;

    // Special-case decode on the live operands, in priority order
    logic              a_is_inf, b_is_inf, a_is_zero, b_is_zero, in_sign;
    logic              spec_hit;
    logic [BF16_W-1:0] spec_res;

    assign a_is_inf  = a_inf | a_ninf;
    assign b_is_inf  = b_inf | b_ninf;
    assign a_is_zero = a_zero | a_sub;
    assign b_is_zero = b_zero | b_sub;
    assign in_sign   = a.sign ^ b.sign;

    always_comb begin
        spec_hit = 1'b1;
        spec_res = BF16_QNAN;
        if (a_nan | b_nan | (a_is_inf & b_is_inf) | (a_is_zero & b_is_zero)) begin
            spec_res = BF16_QNAN;
        end else if (a_is_inf | b_is_zero) begin
            spec_res = {in_sign, BF16_POS_INF_MAG};
        end else if (b_is_inf | a_is_zero) begin
            spec_res = '0;
        end else begin
            spec_hit = 1'b0;
        end
    end

    // One restoring-division step
    logic               rem_ge;
    logic [DIV_Q_W-1:0] rem_sub;

    assign rem_ge  = (rem_q >= DIV_Q_W'(sb_q));
    assign rem_sub = rem_q - DIV_Q_W'(sb_q);

    // Normalise, round to nearest even, then clamp to Inf / +0
    logic signed [DIV_EXP_W-1:0] exp_base, exp_n, exp_r;
    logic [BF16_MAN_W-1:0]       mant, mant_r;
    logic [BF16_SIG_W-1:0]       mant_sum;
    logic                        guard, sticky, round_up;
    logic [BF16_W-1:0]           norm_res;

    always_comb begin
        exp_base = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q});
        if (q_q[DIV_Q_W-1]) begin
            mant   = q_q[8:2];
            guard  = q_q[1];
            sticky = q_q[0] | (rem_q != '0);
            exp_n  = exp_base + $signed(DIV_EXP_W'(BF16_BIAS));
        end else begin
            mant   = q_q[7:1];
            guard  = q_q[0];
            sticky = (rem_q != '0);
            exp_n  = exp_base + $signed(DIV_EXP_W'(BF16_BIAS - 1));
        end
        round_up = guard & (sticky | mant[0]);
        mant_sum = {1'b0, mant} + BF16_SIG_W'(round_up);
        if (mant_sum[BF16_SIG_W-1]) begin
            mant_r = '0;
            exp_r  = exp_n + 10'sd1;
        end else begin
            mant_r = mant_sum[BF16_MAN_W-1:0];
            exp_r  = exp_n;
        end
        if (exp_r >= 10'sd255) begin
            norm_res = {sign_q, BF16_POS_INF_MAG};
        end else if (exp_r <= 10'sd0) begin
            norm_res = '0;
        end else begin
            norm_res = {sign_q, exp_r[BF16_EXP_W-1:0], mant_r};
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        rem_d   = rem_q;
        sb_d    = sb_q;
        ea_d    = ea_q;
        eb_d    = eb_q;
        sign_d  = sign_q;
        c_d     = c_q;
        valid_d = valid_q;

        if (flush_i) begin
            state_d = IDLE;
            valid_d = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid_i) begin
                        sign_d = in_sign;
                        if (spec_hit) begin
                            c_d     = spec_res;
                            valid_d = 1'b1;
                            state_d = DONE;
                        end else begin
                            sb_d    = {1'b1, b.man};
                            ea_d    = a.exp;
                            eb_d    = b.exp;
                            rem_d   = {2'b00, 1'b1, a.man};
                            q_d     = '0;
                            cnt_d   = '0;
                            state_d = DIV;
                        end
                    end
                end
                DIV: begin
                    q_d   = {q_q[DIV_Q_W-2:0], rem_ge};
                    rem_d = rem_ge ? (rem_sub << 1) : (rem_q << 1);
                    cnt_d = cnt_q + DIV_CNT_W'(1);
                    if (cnt_q == DIV_LAST) begin
                        cnt_d   = '0;
                        state_d = NORM;
                    end
                end
                NORM: begin
                    c_d     = norm_res;
                    valid_d = 1'b1;
                    state_d = DONE;
                end
                DONE: begin
                    if (ready_i) begin
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            q_q     <= '0;
            rem_q   <= '0;
            sb_q    <= '0;
            ea_q    <= '0;
            eb_q    <= '0;
            sign_q  <= 1'b0;
            c_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            rem_q   <= rem_d;
            sb_q    <= sb_d;
            ea_q    <= ea_d;
            eb_q    <= eb_d;
            sign_q  <= sign_d;
            c_q     <= c_d;
            valid_q <= valid_d;
        end
    end

    assign ready_o = (state_q == IDLE);
    assign valid_o = valid_q;
    assign c_o     = c_q;

endmodule

// File: tb/tb_bf16_div.sv
// Self-checking bench for bf16_div: arithmetic reference model, cycle-level expectation tracker, directed vectors.
module tb_bf16_div;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush_i = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [15:0] a_i = 16'h0000;
    logic [15:0] b_i = 16'h0000;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [15:0] c_o;

    int n_pass = 0;
    int n_total = 0;

    bf16_div dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .flush_i (flush_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .a_i     (a_i),
        .b_i     (b_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .c_o     (c_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference quotient from the real-valued definition: exact integer division plus RNE
    function automatic logic [15:0] model_div(input logic [15:0] a, input logic [15:0] b);
        int ea, eb, am, bm, n, d, qi, m, g, s, e;
        bit sgn, inex, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        ea = int'(a[14:7]); eb = int'(b[14:7]);
        am = int'(a[6:0]);  bm = int'(b[6:0]);
        sgn = a[15] ^ b[15];
        a_nan = (ea == 255) && (am != 0); b_nan = (eb == 255) && (bm != 0);
        a_inf = (ea == 255) && (am == 0); b_inf = (eb == 255) && (bm == 0);
        a_zero = (ea == 0); b_zero = (eb == 0);
        if (a_nan || b_nan) return 16'h7FC0;
        if ((a_inf && b_inf) || (a_zero && b_zero)) return 16'h7FC0;
        if (a_inf || b_zero) return {sgn, 15'h7F80};
        if (b_inf || a_zero) return 16'h0000;
        n = (128 + am) * 512;
        d = 128 + bm;
        qi = n / d;
        inex = (n % d) != 0;
        e = ea - eb + 127;
        if (qi >= 512) begin
            m = qi >> 2; g = (qi >> 1) & 1; s = (qi & 1) | int'(inex);
        end else begin
            m = qi >> 1; g = qi & 1; s = int'(inex); e = e - 1;
        end
        if (g != 0 && (s != 0 || (m & 1) != 0)) m = m + 1;
        if (m == 256) begin m = 128; e = e + 1; end
        if (e >= 255) return {sgn, 15'h7F80};
        if (e <= 0) return 16'h0000;
        return {sgn, 8'(e), 7'(m)};
    endfunction

    function automatic bit is_special(input logic [15:0] a, input logic [15:0] b);
        return (a[14:7] == 8'hFF) || (b[14:7] == 8'hFF) || (a[14:7] == 8'h00) || (b[14:7] == 8'h00);
    endfunction

    // Cycle-level expectation: busy from accept to handshake, result after 1 or 12 edges
    logic        m_busy, m_valid;
    logic [15:0] m_c, m_pend;
    int          m_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_valid <= 1'b0; m_c <= 16'h0000; m_pend <= 16'h0000; m_cnt <= 0;
        end else if (flush_i) begin
            m_busy <= 1'b0; m_valid <= 1'b0; m_cnt <= 0;
        end else if (!m_busy) begin
            if (valid_i) begin
                m_busy <= 1'b1;
                if (is_special(a_i, b_i)) begin
                    m_valid <= 1'b1; m_c <= model_div(a_i, b_i);
                end else begin
                    m_cnt <= 11; m_pend <= model_div(a_i, b_i);
                end
            end
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin m_valid <= 1'b1; m_c <= m_pend; end
        end else if (m_valid && ready_i) begin
            m_valid <= 1'b0; m_busy <= 1'b0;
        end
    end

    always @(negedge clk) begin
        check("ready_o", 16'(ready_o), 16'(!m_busy));
        check("valid_o", 16'(valid_o), 16'(m_valid));
        check("c_o", c_o, m_c);
    end

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] c;
        int          lat;
        int          hold;
    } vec_t;

    vec_t vecs[12];

    task automatic run_op(input vec_t v);
        int n;
        @(posedge clk); #1;
        check("ready_before_accept", 16'(ready_o), 16'h0001);
        valid_i = 1'b1; a_i = v.a; b_i = v.b;
        @(posedge clk); #1;
        valid_i = 1'b0; a_i = 16'h1234; b_i = 16'h5678;
        n = 1;
        while (!valid_o && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", 16'(n), 16'(v.lat));
        check("result_literal", c_o, v.c);
        check("model_literal", model_div(v.a, v.b), v.c);
        repeat (v.hold) @(posedge clk);
        #1;
        check("held_valid", 16'(valid_o), 16'h0001);
        check("held_c", c_o, v.c);
        check("held_ready", 16'(ready_o), 16'h0000);
        ready_i = 1'b1;
        @(posedge clk); #1;
        ready_i = 1'b0;
        check("idle_after_handshake", 16'(ready_o), 16'h0001);
    endtask

    task automatic start_op(input logic [15:0] a, input logic [15:0] b);
        @(posedge clk); #1;
        valid_i = 1'b1; a_i = a; b_i = b;
        @(posedge clk); #1;
        valid_i = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{16'h40C0, 16'h4000, 16'h4040, 12, 5};
        vecs[1]  = '{16'h3F80, 16'h4040, 16'h3EAB, 12, 0};
        vecs[2]  = '{16'h3F80, 16'h3F80, 16'h3F80, 12, 1};
        vecs[3]  = '{16'hBF80, 16'h0000, 16'hFF80, 1, 0};
        vecs[4]  = '{16'h0000, 16'h0000, 16'h7FC0, 1, 2};
        vecs[5]  = '{16'h7FC1, 16'h3F80, 16'h7FC0, 1, 0};
        vecs[6]  = '{16'h3F80, 16'h7F80, 16'h0000, 1, 0};
        vecs[7]  = '{16'h7F00, 16'h3F00, 16'h7F80, 12, 0};
        vecs[8]  = '{16'h0080, 16'h4000, 16'h0000, 12, 0};
        vecs[9]  = '{16'h0001, 16'h3F80, 16'h0000, 1, 0};
        vecs[10] = '{16'h7F80, 16'hFF80, 16'h7FC0, 1, 0};
        vecs[11] = '{16'hC000, 16'h3F00, 16'hC080, 12, 3};

        #1 rst_n = 1'b0;
        #1;
        check("reset_ready", 16'(ready_o), 16'h0001);
        check("reset_valid", 16'(valid_o), 16'h0000);
        check("reset_c", c_o, 16'h0000);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        foreach (vecs[i]) run_op(vecs[i]);

        // Flush during DIV, then flush together with new operands in IDLE
        start_op(16'h40C0, 16'h4000);
        repeat (3) @(posedge clk);
        #1 flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        check("flush_idle", 16'(ready_o), 16'h0001);
        repeat (15) @(posedge clk);
        #1;
        check("flush_no_result", 16'(valid_o), 16'h0000);
        valid_i = 1'b1; flush_i = 1'b1; a_i = 16'h40C0; b_i = 16'h4000;
        @(posedge clk); #1;
        valid_i = 1'b0; flush_i = 1'b0;
        check("flush_blocks_accept", 16'(ready_o), 16'h0001);
        run_op(vecs[0]);

        // Reset pulse mid-division
        start_op(16'h3F80, 16'h4040);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midop_reset_ready", 16'(ready_o), 16'h0001);
        check("midop_reset_valid", 16'(valid_o), 16'h0000);
        check("midop_reset_c", c_o, 16'h0000);
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        check("reset_no_result", 16'(valid_o), 16'h0000);
        run_op(vecs[1]);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
